// File: rtl/regfile_pkg.sv
// Shared constants and flattened-bus slicing helper for the parametrised register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ZERO_ADDR  = 0;

   // LSB position of lane 'lane' in a flattened bus made of 'width'-bit lanes
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve sets, write clears (reserve wins on a collision),
// and busy_cnt tracks the popcount of the busy vector with an up/down counter.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic                    rsv_en,
   input  logic [ADDR_W-1:0]       rsv_addr,
   output logic [(2**ADDR_W)-1:0]  busy,
   output logic [ADDR_W:0]         busy_cnt
);

   localparam int                DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZA      = ADDR_W'(ZERO_ADDR);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

   logic             clr_ok;
   logic             set_ok;
   logic             inc;
   logic             dec;
   logic [DEPTH-1:0] busy_nxt;
   logic [ADDR_W:0]  cnt_nxt;

   always_comb begin
      clr_ok   = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ZA));
      set_ok   = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ZA));
      busy_nxt = busy;
      if (clr_ok) busy_nxt[wr_addr]  = 1'b0;
      if (set_ok) busy_nxt[rsv_addr] = 1'b1;
      // A release that is re-reserved in the same cycle leaves the count untouched
      inc      = set_ok && !busy[rsv_addr];
      dec      = clr_ok && busy[wr_addr] && !(set_ok && (rsv_addr == wr_addr));
      cnt_nxt  = busy_cnt;
      if (inc && !dec)      cnt_nxt = busy_cnt + CNT_ONE;
      else if (dec && !inc) cnt_nxt = busy_cnt - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/param_reg_file.sv
// Multi-read-port register file with async clear and busy scoreboard.
// Optional same-cycle write-through to the read ports: define REGFILE_BYPASS_EN.
module param_reg_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int                DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZA    = ADDR_W'(ZERO_ADDR);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_ok;

   assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ZA));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy     (busy),
      .busy_cnt (busy_cnt)
   );

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              is_zero;
      logic [DATA_W-1:0] data;
      logic              bsy;

      assign addr = rd_addr[lane_lsb(p, ADDR_W) +: ADDR_W];

      always_comb begin
         is_zero = (ZERO_REG != 0) && (addr == ZA);
         data    = is_zero ? '0 : mem[addr];
         bsy     = is_zero ? 1'b0 : busy[addr];
`ifdef REGFILE_BYPASS_EN
         // A same-address reserve keeps the pre-edge busy bit visible
         if (wr_ok && (wr_addr == addr)) begin
            data = wr_data;
            bsy  = (rsv_en && (rsv_addr == addr)) ? busy[addr] : 1'b0;
         end
`endif
      end

      assign rd_data[lane_lsb(p, DATA_W) +: DATA_W] = data;
      assign rd_busy[p] = bsy;
   end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: a default 32x32/2-port instance checked against a
// behavioural model, plus a 16-bit/8-entry/3-port instance for the parameter sweep.
module tb_param_reg_file;

   localparam int AD = 32, AA = 5, AN = 2;
   localparam int BD = 16, BA = 3, BN = 3;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   logic [AN*AA-1:0] a_rd_addr;
   logic [AN*AD-1:0] a_rd_data;
   logic [AN-1:0]    a_rd_busy;
   logic             a_wr_en, a_rsv_en;
   logic [AA-1:0]    a_wr_addr, a_rsv_addr;
   logic [AD-1:0]    a_wr_data;
   logic [AA:0]      a_busy_cnt;

   logic [BN*BA-1:0] b_rd_addr;
   logic [BN*BD-1:0] b_rd_data;
   logic [BN-1:0]    b_rd_busy;
   logic             b_wr_en, b_rsv_en;
   logic [BA-1:0]    b_wr_addr, b_rsv_addr;
   logic [BD-1:0]    b_wr_data;
   logic [BA:0]      b_busy_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [AD-1:0] m_reg  [32];
   bit            m_busy [32];

   always #5 clk = ~clk;

   param_reg_file #(.DATA_W(AD), .ADDR_W(AA), .NUM_RD(AN), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .busy_cnt(a_busy_cnt)
   );

   param_reg_file #(.DATA_W(BD), .ADDR_W(BA), .NUM_RD(BN), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .busy_cnt(b_busy_cnt)
   );

   // Reference model of dut_a: write then reserve, so a reserve on the same address wins
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i]  <= '0;
            m_busy[i] <= 1'b0;
         end
      end else begin
         if (a_wr_en === 1'b1 && a_wr_addr != 0) begin
            m_reg[a_wr_addr]  <= a_wr_data;
            m_busy[a_wr_addr] <= 1'b0;
         end
         if (a_rsv_en === 1'b1 && a_rsv_addr != 0) m_busy[a_rsv_addr] <= 1'b1;
      end
   end

   function automatic logic [AD-1:0] exp_a_data(input logic [AA-1:0] ad);
      if (ad == 0) return '0;
      if (BYP && a_wr_en === 1'b1 && a_wr_addr == ad) return a_wr_data;
      return m_reg[ad];
   endfunction

   function automatic logic exp_a_busy(input logic [AA-1:0] ad);
      if (ad == 0) return 1'b0;
      if (BYP && a_wr_en === 1'b1 && a_wr_addr == ad)
         return (a_rsv_en === 1'b1 && a_rsv_addr == ad) ? m_busy[ad] : 1'b0;
      return m_busy[ad];
   endfunction

   function automatic int exp_a_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   task automatic a_idle();
      a_wr_en = 1'b0; a_rsv_en = 1'b0;
      a_wr_addr = '0; a_rsv_addr = '0; a_wr_data = '0;
   endtask

   task automatic b_idle();
      b_wr_en = 1'b0; b_rsv_en = 1'b0;
      b_wr_addr = '0; b_rsv_addr = '0; b_wr_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      a_rd_addr = {5'd6, 5'd5};
      #1;
      n_cmp++; if (a_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", a_busy_cnt); end
      n_cmp++; if (a_rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", a_rd_data); end
      n_cmp++; if (b_busy_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt_b got %0d want 0", b_busy_cnt); end
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEAD_BEEF;
      a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pre_reset_r5 got %h want deadbeef", a_rd_data[31:0]); end
      n_cmp++; if (a_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL pre_reset_cnt got %0d want 1", a_busy_cnt); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (a_rd_data !== 64'd0) begin n_fail++; $display("FAIL async_reset_data got %h want 0", a_rd_data); end
      n_cmp++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL async_reset_busy got %b want 00", a_rd_busy); end
      n_cmp++; if (a_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL async_reset_cnt got %0d want 0", a_busy_cnt); end
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h1234_5678;
      a_rd_addr = {5'd7, 5'd7};
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rd_p0 got %h want 12345678", a_rd_data[31:0]); end
      n_cmp++; if (a_rd_data[63:32] !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rd_p1 got %h want 12345678", a_rd_data[63:32]); end
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFF_FFFF;
      a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
      a_rd_addr = {5'd0, 5'd0};
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'd0) begin n_fail++; $display("FAIL r0_same_cycle got %h want 0", a_rd_data[31:0]); end
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_rd_data !== 64'd0) begin n_fail++; $display("FAIL r0_read got %h want 0", a_rd_data); end
      n_cmp++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL r0_busy got %b want 00", a_rd_busy); end
      n_cmp++; if (a_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL r0_cnt got %0d want 0", a_busy_cnt); end
   endtask

   task automatic test_scoreboard();
      a_rd_addr = {5'd3, 5'd3};
      @(negedge clk);
      a_rsv_en = 1'b1; a_rsv_addr = 5'd3;
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_rd_busy !== 2'b11) begin n_fail++; $display("FAIL rsv_busy got %b want 11", a_rd_busy); end
      n_cmp++; if (a_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL rsv_cnt got %0d want 1", a_busy_cnt); end
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hA5;
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_rd_busy !== 2'b00) begin n_fail++; $display("FAIL wr_release_busy got %b want 00", a_rd_busy); end
      n_cmp++; if (a_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL wr_release_cnt got %0d want 0", a_busy_cnt); end
      n_cmp++; if (a_rd_data[31:0] !== 32'hA5) begin n_fail++; $display("FAIL wr_release_data got %h want a5", a_rd_data[31:0]); end
      @(negedge clk);
      a_rsv_en = 1'b1; a_rsv_addr = 5'd3;
      @(negedge clk);
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL double_rsv_cnt got %0d want 1", a_busy_cnt); end
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hA6;
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL double_rsv_release got %0d want 0", a_busy_cnt); end
   endtask

   task automatic test_collision();
      a_rd_addr = {5'd4, 5'd4};
      @(negedge clk);
      a_rsv_en = 1'b1; a_rsv_addr = 5'd4;
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h11;
      a_rsv_en = 1'b1; a_rsv_addr = 5'd4;
      #1;
      n_cmp++; if (a_rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL coll_same_busy got %b want 1", a_rd_busy[0]); end
      n_cmp++; if (a_rd_data[31:0] !== (BYP ? 32'h11 : 32'h0)) begin n_fail++; $display("FAIL coll_same_data got %h want %h", a_rd_data[31:0], BYP ? 32'h11 : 32'h0); end
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_rd_data[31:0] !== 32'h11) begin n_fail++; $display("FAIL coll_data got %h want 11", a_rd_data[31:0]); end
      n_cmp++; if (a_rd_busy !== 2'b11) begin n_fail++; $display("FAIL coll_busy got %b want 11", a_rd_busy); end
      n_cmp++; if (a_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL coll_cnt got %0d want 1", a_busy_cnt); end
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h12;
      @(negedge clk);
      a_idle();
   endtask

   task automatic test_bypass();
      a_rd_addr = {5'd9, 5'd2};
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h55;
      a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
      @(negedge clk);
      a_idle();
      a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h77;
      #1;
      n_cmp++; if (a_rd_data[63:32] !== (BYP ? 32'h77 : 32'h55)) begin n_fail++; $display("FAIL bypass_data got %h want %h", a_rd_data[63:32], BYP ? 32'h77 : 32'h55); end
      n_cmp++; if (a_rd_busy[1] !== (BYP ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL bypass_busy got %b want %b", a_rd_busy[1], !BYP); end
      @(negedge clk);
      a_idle();
      #1;
      n_cmp++; if (a_rd_data[63:32] !== 32'h77) begin n_fail++; $display("FAIL bypass_next got %h want 77", a_rd_data[63:32]); end
      n_cmp++; if (a_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL bypass_cnt got %0d want 0", a_busy_cnt); end
   endtask

   task automatic test_random();
      logic [AA-1:0] ad;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         for (int p = 0; p < AN; p++)
            a_rd_addr[p*AA +: AA] = ($urandom_range(0, 3) == 0) ? AA'($urandom_range(0, 31)) : AA'($urandom_range(0, 7));
         a_wr_en  = ($urandom_range(0, 9) < 4);
         a_rsv_en = ($urandom_range(0, 9) < 4);
         a_wr_addr  = a_wr_en  ? AA'($urandom_range(0, 7)) : 'x;
         a_wr_data  = a_wr_en  ? 32'($urandom()) : 'x;
         a_rsv_addr = a_rsv_en ? AA'($urandom_range(0, 7)) : 'x;
         #1;
         for (int p = 0; p < AN; p++) begin
            ad = a_rd_addr[p*AA +: AA];
            n_cmp++;
            if (a_rd_data[p*AD +: AD] !== exp_a_data(ad)) begin
               n_fail++; $display("FAIL rand_data cyc %0d port %0d r%0d got %h want %h", cyc, p, ad, a_rd_data[p*AD +: AD], exp_a_data(ad));
            end
            n_cmp++;
            if (a_rd_busy[p] !== exp_a_busy(ad)) begin
               n_fail++; $display("FAIL rand_busy cyc %0d port %0d r%0d got %b want %b", cyc, p, ad, a_rd_busy[p], exp_a_busy(ad));
            end
         end
         n_cmp++;
         if (int'(a_busy_cnt) !== exp_a_cnt()) begin
            n_fail++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", cyc, a_busy_cnt, exp_a_cnt());
         end
      end
      @(negedge clk);
      a_idle();
   endtask

   task automatic test_sweep();
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         b_rsv_en = 1'b1; b_rsv_addr = BA'(i);
      end
      @(negedge clk);
      b_rsv_en = 1'b1; b_rsv_addr = 3'd0;
      b_rd_addr = {3'd7, 3'd4, 3'd1};
      #1;
      n_cmp++; if (b_busy_cnt !== 4'd7) begin n_fail++; $display("FAIL sweep_full_cnt got %0d want 7", b_busy_cnt); end
      n_cmp++; if (b_rd_busy !== 3'b111) begin n_fail++; $display("FAIL sweep_full_busy got %b want 111", b_rd_busy); end
      @(negedge clk);
      b_idle();
      b_rd_addr = {3'd0, 3'd0, 3'd0};
      #1;
      n_cmp++; if (b_busy_cnt !== 4'd7) begin n_fail++; $display("FAIL sweep_r0_cnt got %0d want 7", b_busy_cnt); end
      n_cmp++; if (b_rd_busy !== 3'b000) begin n_fail++; $display("FAIL sweep_r0_busy got %b want 000", b_rd_busy); end
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         b_wr_en = 1'b1; b_wr_addr = BA'(i); b_wr_data = 16'(16'h100 + i);
         #1;
         if (i == 4) begin
            n_cmp++; if (b_busy_cnt !== 4'd4) begin n_fail++; $display("FAIL sweep_mid_cnt got %0d want 4", b_busy_cnt); end
         end
      end
      @(negedge clk);
      b_idle();
      b_rd_addr = {3'd3, 3'd2, 3'd7};
      #1;
      n_cmp++; if (b_busy_cnt !== 4'd0) begin n_fail++; $display("FAIL sweep_empty_cnt got %0d want 0", b_busy_cnt); end
      n_cmp++; if (b_rd_data !== {16'h103, 16'h102, 16'h107}) begin n_fail++; $display("FAIL sweep_data got %h want 010301020107", b_rd_data); end
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         b_rsv_en = 1'b1; b_rsv_addr = BA'(i);
      end
      @(negedge clk);
      b_idle();
      b_rd_addr = {3'd3, 3'd2, 3'd1};
      #1;
      n_cmp++; if (b_busy_cnt !== 4'd3) begin n_fail++; $display("FAIL sweep_pre_rst_cnt got %0d want 3", b_busy_cnt); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (b_busy_cnt !== 4'd0) begin n_fail++; $display("FAIL sweep_rst_cnt got %0d want 0", b_busy_cnt); end
      n_cmp++; if (b_rd_data !== 48'd0) begin n_fail++; $display("FAIL sweep_rst_data got %h want 0", b_rd_data); end
      n_cmp++; if (b_rd_busy !== 3'b000) begin n_fail++; $display("FAIL sweep_rst_busy got %b want 000", b_rd_busy); end
      @(negedge clk) rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_idle();
      b_idle();
      a_rd_addr = '0;
      b_rd_addr = '0;
      test_reset();
      test_write_read();
      test_scoreboard();
      test_collision();
      test_bypass();
      test_random();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
